// File: rtl/beep_gen.sv
// Envelope-shaped square-wave beep for the OSD status chime.
// A rising trigger edge runs an attack/sustain/release envelope; the output is a signed sample for a sigma-delta DAC.
module beep_gen #(
    parameter int HALF_PERIOD   = 500,
    parameter int ENV_STEP      = 64,
    parameter int SUSTAIN_TICKS = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        trigger,
    input  logic        mute,
    output logic [15:0] audio_l,
    output logic [15:0] audio_r,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [15:0] TONE_LAST = 16'(HALF_PERIOD - 1);
    localparam logic [15:0] ENV_LAST  = 16'(ENV_STEP - 1);
    localparam logic [15:0] SUS_LAST  = 16'(SUSTAIN_TICKS - 1);

    state_t      state;
    logic [7:0]  amp;
    logic        phase;
    logic [15:0] tone_cnt;
    logic [15:0] env_cnt;
    logic [15:0] sus_cnt;
    logic        trig_q;
    logic        start;
    logic        env_tick;
    logic        tone_wrap;

    // Amplitude sits in bits 14:7, so full scale is +/-32640 with no overflow on negation.
    function automatic logic [15:0] sample(input logic [7:0] a, input logic ph);
        logic [15:0] mag;
        mag = {1'b0, a, 7'b0000000};
        return ph ? mag : (~mag + 16'd1);
    endfunction

    assign start     = trigger & ~trig_q;
    assign env_tick  = (env_cnt == ENV_LAST);
    assign tone_wrap = (tone_cnt == TONE_LAST);

    // Envelope state machine with tone and envelope timebases.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            amp      <= 8'd0;
            phase    <= 1'b1;
            tone_cnt <= 16'd0;
            env_cnt  <= 16'd0;
            sus_cnt  <= 16'd0;
            trig_q   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            trig_q <= trigger;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ATTACK;
                        amp      <= 8'd0;
                        phase    <= 1'b1;
                        tone_cnt <= 16'd0;
                        env_cnt  <= 16'd0;
                        sus_cnt  <= 16'd0;
                        busy     <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                default: begin
                    if (tone_wrap) begin
                        tone_cnt <= 16'd0;
                        phase    <= ~phase;
                    end else begin
                        tone_cnt <= tone_cnt + 16'd1;
                    end
                    // A retrigger restarts the envelope from the current amplitude and swallows any tick.
                    if (start) begin
                        state   <= ATTACK;
                        env_cnt <= 16'd0;
                        sus_cnt <= 16'd0;
                    end else begin
                        env_cnt <= env_tick ? 16'd0 : env_cnt + 16'd1;
                        if (env_tick) begin
                            case (state)
                                ATTACK: begin
                                    if (amp == 8'd255) begin
                                        state <= SUSTAIN;
                                    end else begin
                                        amp <= amp + 8'd1;
                                        if (amp == 8'd254) begin
                                            state <= SUSTAIN;
                                        end else begin
                                            state <= ATTACK;
                                        end
                                    end
                                end
                                SUSTAIN: begin
                                    sus_cnt <= sus_cnt + 16'd1;
                                    if (sus_cnt == SUS_LAST) begin
                                        state <= RELEASE;
                                    end else begin
                                        state <= SUSTAIN;
                                    end
                                end
                                RELEASE: begin
                                    if (amp <= 8'd1) begin
                                        amp      <= 8'd0;
                                        state    <= IDLE;
                                        busy     <= 1'b0;
                                        phase    <= 1'b1;
                                        tone_cnt <= 16'd0;
                                        env_cnt  <= 16'd0;
                                    end else begin
                                        amp <= amp - 8'd1;
                                    end
                                end
                                default: begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            endcase
                        end else begin
                            state <= state;
                        end
                    end
                end
            endcase
        end
    end

    // Output samples lag the envelope by one cycle; mute and IDLE force silence.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            audio_l <= 16'd0;
            audio_r <= 16'd0;
        end else if (mute || (state == IDLE)) begin
            audio_l <= 16'd0;
            audio_r <= 16'd0;
        end else begin
            audio_l <= sample(amp, phase);
            audio_r <= sample(amp, phase);
        end
    end

endmodule
